// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-PC operation codes.
package pc_pkg;

   localparam int unsigned PC_OP_W = 3;

   localparam logic [PC_OP_W-1:0] PC_OP_INC  = 3'd0;
   localparam logic [PC_OP_W-1:0] PC_OP_JMP  = 3'd1;
   localparam logic [PC_OP_W-1:0] PC_OP_JZ   = 3'd2;
   localparam logic [PC_OP_W-1:0] PC_OP_JNZ  = 3'd3;
   localparam logic [PC_OP_W-1:0] PC_OP_CALL = 3'd4;
   localparam logic [PC_OP_W-1:0] PC_OP_RET  = 3'd5;
   localparam logic [PC_OP_W-1:0] PC_OP_HOLD = 3'd6;
   localparam logic [PC_OP_W-1:0] PC_OP_RSV  = 3'd7;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_unit. Push and pop are only honoured when
// legal (not full / not empty); the caller reports the error condition.
module pc_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top_c,
   output logic             full_c,
   output logic             empty_c
);

   localparam int unsigned SP_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SP_W-1:0]  sp;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] top_idx;
   logic [IDX_W-1:0] wr_idx;

   // Status flags and top-of-stack read (sp counts occupied entries)
   always_comb begin
      full_c  = (sp == SP_W'(DEPTH));
      empty_c = (sp == '0);
      top_idx = IDX_W'(sp - SP_W'(1));
      wr_idx  = IDX_W'(sp);
      top_c   = mem[top_idx];
   end

   // Stack pointer; reset empties the stack
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= '0;
      end else if (push && !full_c) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty_c) begin
         sp <= sp - SP_W'(1);
      end
   end

   // Entry storage; contents above sp are don't-care so no reset needed
   always_ff @(posedge clk) begin
      if (!rst && push && !full_c) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next PC each enabled cycle
// (increment, jump, conditional jump on Z, call, return).
// Optional return stack is built when macro PC_STACK_EN is defined;
// otherwise CALL acts as JMP, RET as INC and STACK_ERR stays 0.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic [PC_OP_W-1:0]    OP,
   input  logic [ADDR_WIDTH-1:0] TARGET,
   input  logic                  Z,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic                  STACK_ERR
);

   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  err_next;

`ifdef PC_STACK_EN
   logic                  push;
   logic                  pop;
   logic                  full_c;
   logic                  empty_c;
   logic [ADDR_WIDTH-1:0] top_c;

   pc_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_stack (
      .clk     (CLK),
      .rst     (RST),
      .push    (push),
      .pop     (pop),
      .din     (pc_inc),
      .top_c   (top_c),
      .full_c  (full_c),
      .empty_c (empty_c)
   );
`endif

   // Next-PC mux and stack control; PC+1 wraps naturally at ADDR_WIDTH bits
   always_comb begin
      pc_inc   = PC + ADDR_WIDTH'(1);
      pc_next  = PC;
      err_next = STACK_ERR;
`ifdef PC_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
`endif
      if (EN) begin
         case (OP)
            PC_OP_INC:  pc_next = pc_inc;
            PC_OP_JMP:  pc_next = TARGET;
            PC_OP_JZ:   pc_next = Z ? TARGET : pc_inc;
            PC_OP_JNZ:  pc_next = Z ? pc_inc : TARGET;
            PC_OP_CALL: begin
               pc_next = TARGET;
`ifdef PC_STACK_EN
               if (full_c) begin
                  err_next = 1'b1;
               end else begin
                  push = 1'b1;
               end
`endif
            end
            PC_OP_RET: begin
`ifdef PC_STACK_EN
               if (empty_c) begin
                  pc_next  = pc_inc;
                  err_next = 1'b1;
               end else begin
                  pc_next = top_c;
                  pop     = 1'b1;
               end
`else
               pc_next = pc_inc;
`endif
            end
            PC_OP_HOLD: pc_next = PC;
            default:    pc_next = pc_inc;
         endcase
      end
   end

   // PC and sticky error registers; reset dominates enable
   always_ff @(posedge CLK) begin
      if (RST) begin
         PC        <= '0;
         STACK_ERR <= 1'b0;
      end else begin
         PC        <= pc_next;
         STACK_ERR <= err_next;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model checked every
// cycle, plus hand-computed literal expectations. Honours PC_STACK_EN.
module tb_pc_unit;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          CLK;
   logic          RST;
   logic          EN;
   logic [2:0]    OP;
   logic [AW-1:0] TARGET;
   logic          Z;
   logic [AW-1:0] PC;
   logic          STACK_ERR;

   pc_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EN        (EN),
      .OP        (OP),
      .TARGET    (TARGET),
      .Z         (Z),
      .PC        (PC),
      .STACK_ERR (STACK_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state
   int          m_pc;
   logic        m_err;
   logic [7:0]  m_stk[$];

   // Bookkeeping
   int          n_chk = 0;
   int          n_err = 0;
   bit          chk_on = 1'b0;
   int          lit_seq = 0;
   int          lit_seen = 0;
   string       lit_name;
   logic [7:0]  lit_pc;
   logic        lit_err;

   // Reference model: next state from the architectural rules
   always @(posedge CLK) begin
      int inc;
      inc = (m_pc + 1) % 256;
      if (RST) begin
         m_pc = 0;
         m_err = 1'b0;
         m_stk.delete();
      end else if (EN) begin
         case (OP)
            3'd1: m_pc = int'(TARGET);
            3'd2: m_pc = Z ? int'(TARGET) : inc;
            3'd3: m_pc = Z ? inc : int'(TARGET);
            3'd4: begin
`ifdef PC_STACK_EN
               if (m_stk.size() == DEPTH) m_err = 1'b1;
               else m_stk.push_back(8'(inc));
`endif
               m_pc = int'(TARGET);
            end
            3'd5: begin
`ifdef PC_STACK_EN
               if (m_stk.size() == 0) begin
                  m_pc = inc;
                  m_err = 1'b1;
               end else begin
                  m_pc = int'(m_stk.pop_back());
               end
`else
               m_pc = inc;
`endif
            end
            3'd6: m_pc = m_pc;
            default: m_pc = inc;
         endcase
      end
   end

   // Single compare process: DUT vs model every cycle, plus pending literal checks
   always @(negedge CLK) begin
      if (chk_on) begin
         n_chk++;
         if (PC !== 8'(m_pc)) begin
            n_err++;
            $display("FAIL model_pc t=%0t: got %h want %h", $time, PC, 8'(m_pc));
         end
         n_chk++;
         if (STACK_ERR !== m_err) begin
            n_err++;
            $display("FAIL model_err t=%0t: got %b want %b", $time, STACK_ERR, m_err);
         end
      end
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         n_chk++;
         if (PC !== lit_pc) begin
            n_err++;
            $display("FAIL %s pc: got %h want %h", lit_name, PC, lit_pc);
         end
         n_chk++;
         if (STACK_ERR !== lit_err) begin
            n_err++;
            $display("FAIL %s err: got %b want %b", lit_name, STACK_ERR, lit_err);
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [2:0] o,
                       input logic [7:0] t, input logic zz);
      @(negedge CLK);
      RST = r; EN = e; OP = o; TARGET = t; Z = zz;
      @(posedge CLK);
   endtask

   task automatic expect_lit(input string nm, input logic [7:0] p, input logic e);
      lit_name = nm;
      lit_pc   = p;
      lit_err  = e;
      lit_seq++;
   endtask

   localparam logic [2:0] INC = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                          CALL = 3'd4, RET = 3'd5, HOLD = 3'd6, RSV = 3'd7;

   logic exp_err_ovf;

   initial begin
      RST = 1'b0; EN = 1'b0; OP = INC; TARGET = '0; Z = 1'b0;
      m_pc = 0; m_err = 1'b0;

      // Reset overrides EN/OP
      step(1, 1, JMP, 8'h55, 0);
      chk_on = 1'b1;
      expect_lit("reset", 8'h00, 1'b0);

      // Increment wrap and enable hold
      step(0, 1, JMP, 8'hFF, 0);
      step(0, 1, INC, 8'h12, 1);
      expect_lit("inc_wrap", 8'h00, 1'b0);
      step(0, 0, JMP, 8'h77, 0);
      expect_lit("en_hold", 8'h00, 1'b0);

      // Conditional jumps
      step(0, 1, JMP, 8'h10, 0);
      step(0, 1, JZ, 8'h40, 1);
      expect_lit("jz_taken", 8'h40, 1'b0);
      step(0, 1, JMP, 8'h10, 0);
      step(0, 1, JZ, 8'h40, 0);
      expect_lit("jz_not", 8'h11, 1'b0);
      step(0, 1, JMP, 8'h10, 0);
      step(0, 1, JNZ, 8'h40, 0);
      expect_lit("jnz_taken", 8'h40, 1'b0);
      step(0, 1, JMP, 8'h10, 0);
      step(0, 1, JNZ, 8'h40, 1);
      expect_lit("jnz_not", 8'h11, 1'b0);

      // HOLD and reserved opcode
      step(0, 1, HOLD, 8'h99, 1);
      expect_lit("hold", 8'h11, 1'b0);
      step(0, 1, RSV, 8'h99, 1);
      expect_lit("reserved", 8'h12, 1'b0);

      // Nested call / return
      step(0, 1, JMP, 8'h05, 0);
      step(0, 1, CALL, 8'h20, 0);
      expect_lit("call1", 8'h20, 1'b0);
`ifdef PC_STACK_EN
      step(0, 1, CALL, 8'h30, 1);
      expect_lit("call2", 8'h30, 1'b0);
      step(0, 1, RET, 8'hAA, 0);
      expect_lit("ret1", 8'h21, 1'b0);
      step(0, 1, RET, 8'hAA, 1);
      expect_lit("ret2", 8'h06, 1'b0);
`else
      step(0, 1, RET, 8'hAA, 0);
      expect_lit("ret_as_inc", 8'h21, 1'b0);
`endif

      // Overflow: five calls into a four-entry stack
      step(0, 1, JMP, 8'h00, 0);
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, CALL, 8'(8'h80 + i), 0);
      end
`ifdef PC_STACK_EN
      exp_err_ovf = 1'b1;
`else
      exp_err_ovf = 1'b0;
`endif
      expect_lit("overflow", 8'h85, exp_err_ovf);
      step(0, 1, RET, 8'h00, 0);
`ifdef PC_STACK_EN
      expect_lit("ret_after_ovf", 8'h84, 1'b1);
`else
      expect_lit("ret_after_ovf", 8'h86, 1'b0);
`endif
      step(0, 0, JMP, 8'h33, 0);

      // Reset clears the sticky flag and stack, then underflow
      step(1, 1, CALL, 8'h44, 0);
      expect_lit("reset2", 8'h00, 1'b0);
      step(0, 1, JMP, 8'h07, 0);
      step(0, 1, RET, 8'h00, 0);
      expect_lit("underflow", 8'h08, exp_err_ovf);
      step(0, 1, INC, 8'h00, 0);
      expect_lit("err_sticky", 8'h09, exp_err_ovf);

      // Reset mid-call-chain discards return addresses
      step(0, 1, CALL, 8'h60, 0);
      step(1, 0, INC, 8'h00, 0);
      step(0, 1, RET, 8'h00, 0);
      expect_lit("ret_after_rst", 8'h01, exp_err_ovf);

      // Mixed directed/pseudo-random traffic, checked against the model
      for (int i = 0; i < 80; i++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
              3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end

      @(negedge CLK);
      @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
